// File: rtl/adc0809_responder.sv
// adc0809_responder: synthesizable stand-in for an ADC0809 8-channel converter.
// It answers the controller's ale/start/out_en handshake with eoc and result.
// The conversion is a SAR search against a per-channel 8-bit level taken from analog_in.
// Optional build macro ADC_NOISE_EN adds an LFSR that dithers the sampled level by +/-1.
module adc0809_responder #(
    parameter int unsigned BIT_CLKS  = 8,
    parameter int unsigned EOC_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adc_clk,
    input  logic        ale,
    input  logic        start,
    input  logic        out_en,
    input  logic [2:0]  addr,
    input  logic [63:0] analog_in,
    output logic        eoc,
    output logic [7:0]  result,
    output logic        busy
);

    localparam int unsigned MAX_CNT = (BIT_CLKS > EOC_DELAY) ? BIT_CLKS : EOC_DELAY;
    localparam int unsigned CW = $clog2(MAX_CNT) + 1;
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(EOC_DELAY - 1);

    typedef enum logic [1:0] {IDLE, ARMED, DELAY, CONVERT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    sar_q, sar_d;
    logic [7:0]    snap_q, snap_d;
    logic [2:0]    chan_q, chan_d;
    logic [7:0]    latch_q, latch_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;

    logic adcClkPrev_q, alePrev_q, startPrev_q;
    logic adcRise, aleRise, startRise, startFall;

    logic [7:0] snapRaw;
    logic [7:0] snapIn;
    logic [7:0] trialMask;
    logic [7:0] decided;

    assign adcRise   = adc_clk & ~adcClkPrev_q;
    assign aleRise   = ale & ~alePrev_q;
    assign startRise = start & ~startPrev_q;
    assign startFall = ~start & startPrev_q;

    assign snapRaw   = analog_in[{chan_q, 3'b000} +: 8];
    assign trialMask = 8'b1 << bitIdx_q;
    assign decided   = (sar_q <= snap_q) ? sar_q : (sar_q & ~trialMask);

`ifdef ADC_NOISE_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsrFb;

    assign lfsrFb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // Dither the sampled level by +/-1 from the LFSR, saturating at both code limits.
    always_comb begin
        snapIn = snapRaw;
        if (lfsr_q[1:0] == 2'b01 && snapRaw != 8'hFF) begin
            snapIn = snapRaw + 8'd1;
        end else if (lfsr_q[1:0] == 2'b10 && snapRaw != 8'h00) begin
            snapIn = snapRaw - 8'd1;
        end
    end

    // The LFSR steps once for every conversion that actually begins sampling.
    always_comb begin
        lfsr_d = lfsr_q;
        if (!startRise && state_q == ARMED && startFall) begin
            lfsr_d = {lfsr_q[6:0], lfsrFb};
        end
    end

    // LFSR register, reseeded on reset so dither sequences are repeatable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign snapIn = snapRaw;
`endif

    // One-deep history of the handshake inputs so edges are seen one clk later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adcClkPrev_q <= 1'b0;
            alePrev_q    <= 1'b0;
            startPrev_q  <= 1'b0;
        end else begin
            adcClkPrev_q <= adc_clk;
            alePrev_q    <= ale;
            startPrev_q  <= start;
        end
    end

    // Conversion state machine: a start rise always re-arms, otherwise step by state.
    always_comb begin
        state_d  = state_q;
        sar_d    = sar_q;
        snap_d   = snap_q;
        chan_d   = chan_q;
        latch_d  = latch_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;

        if (aleRise) begin
            chan_d = addr;
        end

        if (startRise) begin
            state_d = ARMED;
            sar_d   = 8'h00;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ARMED: begin
                    if (startFall) begin
                        snap_d   = snapIn;
                        cnt_d    = '0;
                        bitIdx_d = 3'd7;
                        state_d  = DELAY;
                    end
                end
                DELAY: begin
                    if (adcRise) begin
                        if (cnt_q == DELAY_LAST) begin
                            cnt_d    = '0;
                            sar_d    = 8'h80;
                            bitIdx_d = 3'd7;
                            state_d  = CONVERT;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    if (adcRise) begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_d = '0;
                            if (bitIdx_q == 3'd0) begin
                                sar_d   = decided;
                                latch_d = decided;
                                state_d = IDLE;
                            end else begin
                                sar_d    = decided | (trialMask >> 1);
                                bitIdx_d = bitIdx_q - 3'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sar_q    <= 8'h00;
            snap_q   <= 8'h00;
            chan_q   <= 3'd0;
            latch_q  <= 8'h00;
            cnt_q    <= '0;
            bitIdx_q <= 3'd7;
        end else begin
            state_q  <= state_d;
            sar_q    <= sar_d;
            snap_q   <= snap_d;
            chan_q   <= chan_d;
            latch_q  <= latch_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
        end
    end

    assign eoc    = (state_q != CONVERT);
    assign busy   = (state_q != IDLE);
    assign result = out_en ? latch_q : 8'h00;

endmodule

// File: tb/tb_adc0809_responder.sv
// tb_adc0809_responder: scenario-based bench for the ADC0809 emulator.
// Expected conversion codes go into a scoreboard queue when a conversion is started.
// They are popped and compared when the conversion finishes.
module tb_adc0809_responder;

    logic        clk;
    logic        reset;
    logic        adc_clk;
    logic        ale;
    logic        start;
    logic        out_en;
    logic [2:0]  addr;
    logic [63:0] analog_in;
    logic        eoc;
    logic [7:0]  result;
    logic        busy;

    int compared;
    int mismatched;
    logic [7:0] sbq[$];
    logic [7:0] exp;

    adc0809_responder dut (
        .clk       (clk),
        .reset     (reset),
        .adc_clk   (adc_clk),
        .ale       (ale),
        .start     (start),
        .out_en    (out_en),
        .addr      (addr),
        .analog_in (analog_in),
        .eoc       (eoc),
        .result    (result),
        .busy      (busy)
    );

    // Free-running system clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setChan(input int ch, input logic [7:0] val);
        analog_in[ch*8 +: 8] = val;
    endtask

    task automatic adcEdges(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            adc_clk = 1'b1;
            repeat (2) @(negedge clk);
            adc_clk = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic pulseAle(input logic [2:0] a);
        @(negedge clk);
        addr = a;
        ale  = 1'b1;
        repeat (2) @(negedge clk);
        ale = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic startPulse(input logic [7:0] expected);
        sbq.push_back(expected);
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (eoc !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_eoc: got %b expected 1", eoc);
        end
        compared++;
        if (result !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_result: got %h expected 00", result);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        setChan(3, 8'h5A);
        pulseAle(3'd3);
        startPulse(8'h5A);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_busy: got %b expected 1", busy);
        end
        adcEdges(1);
        compared++;
        if (eoc !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_eoc_delay1: got %b expected 1", eoc);
        end
        adcEdges(1);
        compared++;
        if (eoc !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_eoc_edge2: got %b expected 0", eoc);
        end
        adcEdges(63);
        compared++;
        if (eoc !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_eoc_edge65: got %b expected 0", eoc);
        end
        compared++;
        if (result !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL single_result_prev: got %h expected 00", result);
        end
        adcEdges(1);
        compared++;
        if (eoc !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_eoc_edge66: got %b expected 1", eoc);
        end
        exp = sbq.pop_front();
        compared++;
        if (result !== exp) begin
            mismatched++;
            $display("[TB] FAIL single_result: got %h expected %h", result, exp);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_busy_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        pulseAle(3'd0);
        setChan(0, 8'hFF);
        startPulse(8'hFF);
        adcEdges(66);
        exp = sbq.pop_front();
        compared++;
        if (result !== exp) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got %h expected %h", result, exp);
        end
        setChan(0, 8'h00);
        startPulse(8'h00);
        adcEdges(10);
        compared++;
        if (result !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL b2b_hold: got %h expected ff", result);
        end
        adcEdges(56);
        exp = sbq.pop_front();
        compared++;
        if (result !== exp) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got %h expected %h", result, exp);
        end
    endtask

    task automatic test_abort();
        setChan(0, 8'h80);
        startPulse(8'h80);
        adcEdges(29);
        compared++;
        if (eoc !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_converting: got %b expected 0", eoc);
        end
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (eoc !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL abort_eoc: got %b expected 1", eoc);
        end
        compared++;
        if (result !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL abort_latch_kept: got %h expected 00", result);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        adcEdges(66);
        exp = sbq.pop_front();
        compared++;
        if (result !== exp) begin
            mismatched++;
            $display("[TB] FAIL abort_restart: got %h expected %h", result, exp);
        end
    endtask

    task automatic test_snapshot();
        setChan(0, 8'h33);
        setChan(5, 8'h5C);
        startPulse(8'h33);
        adcEdges(20);
        setChan(0, 8'hCC);
        pulseAle(3'd5);
        compared++;
        if (result !== 8'h80) begin
            mismatched++;
            $display("[TB] FAIL snapshot_hold: got %h expected 80", result);
        end
        adcEdges(46);
        exp = sbq.pop_front();
        compared++;
        if (result !== exp) begin
            mismatched++;
            $display("[TB] FAIL snapshot_kept: got %h expected %h", result, exp);
        end
        startPulse(8'h5C);
        adcEdges(66);
        exp = sbq.pop_front();
        compared++;
        if (result !== exp) begin
            mismatched++;
            $display("[TB] FAIL snapshot_newchan: got %h expected %h", result, exp);
        end
    endtask

    task automatic test_out_en();
        setChan(5, 8'h77);
        out_en = 1'b0;
        startPulse(8'h77);
        for (int k = 0; k < 6; k++) begin
            adcEdges(11);
            compared++;
            if (result !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL outen_low_%0d: got %h expected 00", k, result);
            end
        end
        out_en = 1'b1;
        @(negedge clk);
        exp = sbq.pop_front();
        compared++;
        if (result !== exp) begin
            mismatched++;
            $display("[TB] FAIL outen_high: got %h expected %h", result, exp);
        end
    endtask

    task automatic test_reset_mid();
        setChan(5, 8'h42);
        startPulse(8'h42);
        adcEdges(43);
        #2;
        reset = 1'b1;
        #1;
        exp = sbq.pop_back();
        compared++;
        if (eoc !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rstmid_eoc: got %b expected 1", eoc);
        end
        compared++;
        if (result !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL rstmid_result: got %h expected 00", result);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            adcEdges(1);
            compared++;
            if (eoc !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL rstmid_quiet_%0d: got %b expected 1", k, eoc);
            end
        end
        compared++;
        if (result !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL rstmid_latch: got %h expected 00", result);
        end
        pulseAle(3'd5);
        startPulse(8'h42);
        adcEdges(66);
        exp = sbq.pop_front();
        compared++;
        if (result !== exp) begin
            mismatched++;
            $display("[TB] FAIL rstmid_recover: got %h expected %h", result, exp);
        end
        compared++;
        if (sbq.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sbq.size());
        end
    endtask

    // Scenario sequence; a watchdog below bounds the whole run.
    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        adc_clk    = 1'b0;
        ale        = 1'b0;
        start      = 1'b0;
        out_en     = 1'b1;
        addr       = 3'd0;
        analog_in  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_snapshot();
        test_out_en();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Time limit guarding against a stalled run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/adc0809_responder.md
Name: adc0809_responder

Overview:
- Synthesizable emulator of the ADC0809 8-channel converter. It is the responder side of the start/ale/out_en/eoc/result handshake that the team's ADC controller initiates.
- Lets the ADC→FND→step-motor chain run on the board, and in benches, with no physical converter fitted.
- Analog levels come from a packed 8×8-bit input bus, typically DIP switches on channel 0 and test patterns on the rest.
- Sits where the external chip would be: its outputs feed the controller's eoc/result inputs.

Parameters:
- BIT_CLKS, 8, adc_clk rising edges spent per SAR bit decision (conversion = 8×BIT_CLKS edges).
- EOC_DELAY, 2, adc_clk rising edges from start falling edge until eoc drops.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- adc_clk  input  1  converter clock from the controller; synchronous to clk; sampled and edge-detected in clk domain.
- ale  input  1  address latch enable; addr captured on rising edge.
- start  input  1  conversion start; rising edge aborts/clears SAR, falling edge begins conversion.
- out_en  input  1  output enable for result bus.
- addr  input  3  channel select.
- analog_in  input  64  channel n level = analog_in[8n+7:8n].
- eoc  output  1  end of conversion; high = idle/done, low = converting.
- result  output  8  converted value when out_en=1, else 8'h00.
- busy  output  1  debug: high in ARMED, DELAY or CONVERT states.

Behaviour:
- Reset values (async, active-high):
  - eoc=1, result=8'h00, busy=0.
  - Internal registers clear: latched channel=0, output latch=0, SAR=0, state=IDLE.
- Edge detection:
  - Registered copies of adc_clk, ale and start, one clk cycle deep.
  - An edge is acted on in the clk cycle after it appears at the input.
- ALE:
  - On an ale rising edge, latch addr into the channel register in any state.
  - A conversion already sampling keeps its snapshot.
- States: IDLE, ARMED, DELAY, CONVERT.
  - IDLE: eoc=1. A start rising edge clears SAR and goes to ARMED.
  - ARMED: eoc=1. On the start falling edge:
    - snapshot = analog_in[latched channel];
    - clear the edge counter and bit index (7);
    - go to DELAY.
  - DELAY: eoc=1. Count adc_clk rising edges. On the EOC_DELAY-th edge, eoc goes to 0 and the state goes to CONVERT.
  - CONVERT: eoc=0. Each bit runs from a trial setting to a decision:
    - At bit start, set the trial bit SAR[i]=1.
    - After BIT_CLKS adc_clk edges, keep the bit if SAR ≤ snapshot, else clear it.
    - Then i decrements. After bit 0, the output latch is loaded with SAR in the same clk cycle, eoc returns to 1 and the state goes to IDLE.
- Total conversion time: EOC_DELAY + 8×BIT_CLKS adc_clk edges after the start falling edge (66 at defaults).
- A start rising edge in ARMED, DELAY or CONVERT aborts:
  - clear SAR, eoc=1 in the next clk cycle, go to ARMED;
  - the output latch keeps its previous value.
- Output latch:
  - Changes only at the end of a conversion.
  - During a conversion, result with out_en=1 shows the previous value.
- Result bus: result = out_en ? latch : 8'h00, purely combinational from the latch. Asserting out_en has no effect on state.
- If adc_clk is stuck, the state machine stalls in DELAY or CONVERT with no timeout. Only start or reset recovers.
- Reset mid-conversion returns everything to reset values immediately. The aborted conversion never produces eoc or a latch update.
- Final SAR equals the snapshot exactly when the optional feature is off.
- Changes to analog_in after the snapshot do not affect the conversion.

Optional Feature:
- Macro: ADC_NOISE_EN.
- With the macro defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances once per conversion start.
  - The snapshot is adjusted by +1 if LFSR[1:0]=2'b01 and by −1 if 2'b10, otherwise unchanged.
  - The adjustment saturates at 8'h00 and 8'hFF.
- Without the macro: no LFSR logic, and the snapshot is analog_in exactly.

Test Plan:
- Reset, then an ale pulse with addr=3, then a start pulse with channel 3 = 8'h5A → eoc high during the 2 DELAY edges, low for 64 edges, high after the 66th edge; with out_en=1, result=8'h5A.
- Back-to-back conversions, channel 0 = 8'hFF then 8'h00 → results 8'hFF then 8'h00 (boundary codes). During the second conversion, result shows 8'hFF.
- Conversion of 8'h80 on channel 0 with a new start pulse at CONVERT bit 4 → eoc rises within 2 clk; the latch keeps its prior value; the restarted conversion yields 8'h80.
- During CONVERT, change analog_in from 8'h33 to 8'hCC and pulse ale with addr=5 → result=8'h33; the next conversion uses channel 5.
- out_en=0 throughout a conversion of 8'h77 → result reads 8'h00; raising out_en afterwards → 8'h77.
- Assert reset at bit 2 of CONVERT → eoc=1 and result=8'h00 asynchronously; no later eoc edge until a new start.
